// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: fixed VGA scanout slot on active pixel
// clocks, host read/write port on every other cycle.
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int SHIFT  = 2,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              hsync,
  output logic              vsync,
  output logic [1:0]        r,
  output logic [1:0]        g,
  output logic [1:0]        b,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [5:0]        host_wdata,
  output logic              host_rvalid,
  output logic [5:0]        host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [5:0]        mem_wdata,
  input  logic [5:0]        mem_rdata
);

  localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  logic              active;
  logic              scan_slot;
  logic              host_acc;
  logic              in_range;
  logic              line_end;
  logic              frame_end;
  logic [ADDR_W-1:0] col;

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              synced_q, synced_d;
  logic              fetch_q, fetch_d;
  logic [5:0]        pix_hold_q, pix_hold_d;
  logic              act_q, act_d;
  logic              hs_p_q, hs_p_d;
  logic              vs_p_q, vs_p_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [5:0]        rgb_q, rgb_d;
  logic              rvalid_q, rvalid_d;
  logic              rd_ok_q, rd_ok_d;

  assign active    = (x < 10'd640) && (y < 10'd480);
  assign scan_slot = pix_ce && active && synced_q;
  assign line_end  = pix_ce && (x == 10'd799);
  assign frame_end = line_end && (y == 10'd523);
  assign col       = ADDR_W'(x >> SHIFT);
  assign in_range  = {1'b0, host_addr} < FB_SIZE;

  // RAM port mux: scanout wins its slot, host takes the rest
  always_comb begin
    host_ready = ~scan_slot & ~rst;
    host_acc   = host_valid & host_ready;
    mem_addr   = host_addr;
    mem_we     = host_acc & host_we & in_range;
    mem_wdata  = host_wdata;
    if (scan_slot) begin
      mem_addr = row_base_q + col;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign r           = rgb_q[5:4];
  assign g           = rgb_q[3:2];
  assign b           = rgb_q[1:0];
  assign host_rvalid = rvalid_q;
  assign host_rdata  = (rvalid_q && rd_ok_q) ? mem_rdata : 6'd0;

  // next-state for the pixel pipeline, row tracking and host read return
  always_comb begin
    row_base_d = row_base_q;
    synced_d   = synced_q;
    fetch_d    = scan_slot;
    pix_hold_d = pix_hold_q;
    act_d      = act_q;
    hs_p_d     = hs_p_q;
    vs_p_d     = vs_p_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    rgb_d      = rgb_q;
    rvalid_d   = host_acc & ~host_we;
    rd_ok_d    = in_range;
    if (fetch_q) begin
      pix_hold_d = mem_rdata;
    end
    if (pix_ce) begin
      rgb_d   = act_q ? pix_hold_q : 6'd0;
      act_d   = active & synced_q;
      hsync_d = hs_p_q;
      vsync_d = vs_p_q;
      hs_p_d  = hsync_in;
      vs_p_d  = vsync_in;
    end
    if (line_end) begin
      if (y == 10'd523) begin
        row_base_d = '0;
      end else if ((y < 10'd480) && (&y[SHIFT-1:0])) begin
        row_base_d = row_base_q + ROW_STEP;
      end
    end
    if (frame_end) begin
      synced_d = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_q <= '0;
      synced_q   <= 1'b0;
      fetch_q    <= 1'b0;
      pix_hold_q <= '0;
      act_q      <= 1'b0;
      hs_p_q     <= 1'b0;
      vs_p_q     <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      rgb_q      <= '0;
      rvalid_q   <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      row_base_q <= row_base_d;
      synced_q   <= synced_d;
      fetch_q    <= fetch_d;
      pix_hold_q <= pix_hold_d;
      act_q      <= act_d;
      hs_p_q     <= hs_p_d;
      vs_p_q     <= vs_p_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
      rvalid_q   <= rvalid_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed vector table, line/frame sequences
// and random host traffic against a pixel-level reference model.
module tb_vga_fb_arbiter;

  logic        clk;
  logic        rst;
  logic        pix_ce;
  logic [9:0]  x, y;
  logic        hsync_in, vsync_in;
  logic        hsync, vsync;
  logic [1:0]  r, g, b;
  logic        host_valid, host_ready, host_we;
  logic [14:0] host_addr;
  logic [5:0]  host_wdata;
  logic        host_rvalid;
  logic [5:0]  host_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] seed_px(int i);
    return 6'((i * 37) ^ (i >> 5) ^ 21);
  endfunction

  // external single-port RAM, registered read
  logic [5:0] ram [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++)
      ram[i] = (i < 19200) ? seed_px(i) : 6'd0;
    mem_rdata = 6'd0;
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // reference model state
  logic [5:0] ref_fb [0:19199];
  logic       m_sync;
  logic [5:0] m_pix, m_rgb, m_rdata;
  logic       m_hs, m_vs, m_hs_p, m_vs_p, m_rvalid;

  int n_cmp, n_bad;
  int stall_act, stall_blank;
  logic [5:0] obs [0:7];

  typedef struct {
    logic       rs;
    logic       pce;
    int         xx;
    int         yy;
    logic       hv;
    logic       hwe;
    int         a;
    logic [5:0] wd;
    logic       e_ready;
    logic       e_we;
    logic       e_rvalid;
    logic [5:0] e_rdata;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mkv(logic rs, logic pce, int xx, int yy,
      logic hv, logic hwe, int a, logic [5:0] wd,
      logic er, logic ew, logic ev, logic [5:0] ed);
    vec_t v;
    v.rs = rs; v.pce = pce; v.xx = xx; v.yy = yy;
    v.hv = hv; v.hwe = hwe; v.a = a; v.wd = wd;
    v.e_ready = er; v.e_we = ew; v.e_rvalid = ev; v.e_rdata = ed;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic rs, logic pce, int xx, int yy,
      logic hv, logic hwe, int a, logic [5:0] wd);
    rst        = rs;
    pix_ce     = pce;
    x          = 10'(xx);
    y          = 10'(yy);
    hsync_in   = !(xx >= 656 && xx < 752);
    vsync_in   = !(yy >= 490 && yy < 492);
    host_valid = hv;
    host_we    = hwe;
    host_addr  = 15'(a);
    host_wdata = wd;
  endtask

  task automatic mid_check();
    logic act, scan, er, acc, ewe;
    @(negedge clk);
    act  = (x < 640) && (y < 480);
    scan = pix_ce && act && m_sync;
    er   = !rst && !scan;
    chk("host_ready", int'(host_ready), int'(er));
    if (!host_ready && !rst) begin
      if (x < 640) stall_act++;
      else stall_blank++;
    end
    acc = host_valid && er;
    ewe = acc && host_we && (host_addr < 19200);
    chk("mem_we", int'(mem_we), int'(ewe));
    if (acc) chk("mem_addr_host", int'(mem_addr), int'(host_addr));
    if (ewe) chk("mem_wdata", int'(mem_wdata), int'(host_wdata));
    if (scan && !rst)
      chk("mem_addr_scan", int'(mem_addr), (int'(y) / 4) * 160 + int'(x) / 4);
    chk("rgb", int'({r, g, b}), int'(m_rgb));
    chk("hsync", int'(hsync), int'(m_hs));
    chk("vsync", int'(vsync), int'(m_vs));
    chk("host_rvalid", int'(host_rvalid), int'(m_rvalid));
    chk("host_rdata", int'(host_rdata), int'(m_rdata));
  endtask

  task automatic edge_update();
    logic act, scan, acc;
    int a, idx;
    act  = (x < 640) && (y < 480);
    scan = pix_ce && act && m_sync;
    acc  = host_valid && !rst && !scan;
    a    = int'(host_addr);
    idx  = (int'(y) / 4) * 160 + int'(x) / 4;
    @(posedge clk);
    if (rst) begin
      m_sync = 0; m_pix = 0; m_rgb = 0; m_rdata = 0;
      m_hs = 0; m_vs = 0; m_hs_p = 0; m_vs_p = 0; m_rvalid = 0;
    end else begin
      m_rvalid = acc && !host_we;
      m_rdata  = (acc && !host_we && a < 19200) ? ref_fb[a] : 6'd0;
      if (acc && host_we && a < 19200) ref_fb[a] = host_wdata;
      if (pix_ce) begin
        m_rgb  = m_pix;
        m_hs   = m_hs_p;
        m_vs   = m_vs_p;
        m_hs_p = hsync_in;
        m_vs_p = vsync_in;
        m_pix  = (act && m_sync) ? ref_fb[idx] : 6'd0;
        if (x == 799 && y == 523) m_sync = 1;
      end
    end
    #1;
  endtask

  task automatic cyc(logic rs, logic pce, int xx, int yy,
      logic hv, logic hwe, int a, logic [5:0] wd);
    drive(rs, pce, xx, yy, hv, hwe, a, wd);
    mid_check();
    edge_update();
  endtask

  task automatic rnd_host(output logic hv, output logic hwe,
      output int a, output logic [5:0] wd);
    hv  = ($urandom % 4) != 0;
    hwe = ($urandom % 2) != 0;
    if ($urandom % 8 == 0) a = 19200 + int'($urandom % 13568);
    else a = 2 + int'($urandom % 19198);
    wd = 6'($urandom);
  endtask

  task automatic run_line(int yy, bit full, int rst_x);
    logic hv, hwe;
    int a;
    logic [5:0] wd;
    stall_act   = 0;
    stall_blank = 0;
    for (int xi = (full ? 0 : 799); xi < 800; xi++) begin
      for (int c = 0; c < 4; c++) begin
        rnd_host(hv, hwe, a, wd);
        drive(xi == rst_x && c == 0, c == 0, xi, yy, hv, hwe, a, wd);
        mid_check();
        if (c == 0 && yy == 4 && xi == 0)
          chk("row4_addr", int'(mem_addr), 160);
        if (c == 0 && yy == 479 && xi == 636)
          chk("row479_addr", int'(mem_addr), 19199);
        edge_update();
        if (xi == rst_x && c == 0)
          chk("rgb_after_rst", int'({r, g, b}), 0);
      end
      if (yy == 0 && xi >= 1 && xi <= 8) obs[xi-1] = {r, g, b};
    end
  endtask

  task automatic check_obs(string nm);
    for (int k = 0; k < 8; k++)
      chk(nm, int'(obs[k]), (k < 4) ? 'h3F : 'h15);
  endtask

  initial begin
    int tot;
    n_cmp = 0; n_bad = 0;
    stall_act = 0; stall_blank = 0;
    for (int i = 0; i < 19200; i++) ref_fb[i] = seed_px(i);
    m_sync = 0; m_pix = 0; m_rgb = 0; m_rdata = 0;
    m_hs = 0; m_vs = 0; m_hs_p = 0; m_vs_p = 0; m_rvalid = 0;

    tbl[0]  = mkv(0, 0,  0, 0, 1, 1,     5, 6'h2A, 1, 1, 0, 6'h00);
    tbl[1]  = mkv(0, 0,  0, 0, 1, 0,     5, 6'h00, 1, 0, 0, 6'h00);
    tbl[2]  = mkv(0, 0,  0, 0, 0, 0,     0, 6'h00, 1, 0, 1, 6'h2A);
    tbl[3]  = mkv(0, 0,  0, 0, 1, 1, 19200, 6'h11, 1, 0, 0, 6'h00);
    tbl[4]  = mkv(0, 0,  0, 0, 1, 0, 19200, 6'h00, 1, 0, 0, 6'h00);
    tbl[5]  = mkv(0, 0,  0, 0, 0, 0,     0, 6'h00, 1, 0, 1, 6'h00);
    tbl[6]  = mkv(0, 0,  0, 0, 1, 1, 19199, 6'h07, 1, 1, 0, 6'h00);
    tbl[7]  = mkv(0, 0,  0, 0, 1, 0, 19199, 6'h00, 1, 0, 0, 6'h00);
    tbl[8]  = mkv(0, 0,  0, 0, 0, 0,     0, 6'h00, 1, 0, 1, 6'h07);
    tbl[9]  = mkv(0, 1,  0, 0, 1, 1,     3, 6'h09, 1, 1, 0, 6'h00);
    tbl[10] = mkv(1, 0,  0, 0, 1, 1,     6, 6'h33, 0, 0, 0, 6'h00);
    tbl[11] = mkv(0, 0,  0, 0, 1, 0,     6, 6'h00, 1, 0, 0, 6'h00);
    tbl[12] = mkv(0, 0,  0, 0, 0, 0,     0, 6'h00, 1, 0, 1, seed_px(6));
    tbl[13] = mkv(0, 1, 10, 5, 1, 0, 19300, 6'h00, 1, 0, 0, 6'h00);
    tbl[14] = mkv(0, 0,  0, 0, 0, 0,     0, 6'h00, 1, 0, 1, 6'h00);

    drive(1, 0, 0, 0, 0, 0, 0, 6'h00);
    edge_update();
    edge_update();
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_rvalid", int'(host_rvalid), 0);
    chk("rst_rdata", int'(host_rdata), 0);
    chk("rst_mem_we", int'(mem_we), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].pce, tbl[i].xx, tbl[i].yy,
            tbl[i].hv, tbl[i].hwe, tbl[i].a, tbl[i].wd);
      mid_check();
      chk("tbl_ready", int'(host_ready), int'(tbl[i].e_ready));
      chk("tbl_we", int'(mem_we), int'(tbl[i].e_we));
      chk("tbl_rvalid", int'(host_rvalid), int'(tbl[i].e_rvalid));
      chk("tbl_rdata", int'(host_rdata), int'(tbl[i].e_rdata));
      edge_update();
    end

    cyc(0, 0, 0, 0, 1, 1, 0, 6'h3F);
    cyc(0, 0, 0, 0, 1, 1, 1, 6'h15);
    cyc(0, 0, 0, 0, 0, 0, 0, 6'h00);

    run_line(523, 0, -1);
    run_line(0, 1, -1);
    check_obs("line0_frame1");
    chk("line0_active_stalls", stall_act, 640);
    chk("line0_blank_stalls", stall_blank, 0);
    for (int yy = 1; yy < 524; yy++)
      run_line(yy, (yy == 4 || yy == 479), -1);

    run_line(0, 1, -1);
    check_obs("line0_frame2");
    for (int yy = 1; yy < 100; yy++) run_line(yy, 0, -1);
    run_line(100, 1, 300);
    chk("line100_stalls", stall_act + stall_blank, 300);
    tot = 0;
    for (int yy = 101; yy < 524; yy++) begin
      run_line(yy, (yy == 200), -1);
      tot += stall_act + stall_blank;
    end
    chk("unsynced_stalls", tot, 0);

    run_line(0, 1, -1);
    check_obs("line0_frame3");
    chk("resume_active_stalls", stall_act, 640);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
